// File: rtl/adler32_pkg.sv
// Shared constants and helpers for the wide Adler-32 engine.
//
// Contents:
//   ADLER_MOD   - Adler-32 modulus (largest prime below 2^16).
//   ADLER_INIT  - checksum of an empty message, {B,A} = {0,1}.
//   MAX_BPB     - widest supported beat, in bytes.
//   K_W/S1_W/S2_W/SUM_W/RED_W - widths of the per-beat and accumulator terms.
//   popcount()  - number of set bits in a keep mask.
//   mod_once()  - single conditional subtract; reduces any 16-bit value below ADLER_MOD.
package adler32_pkg;

  localparam logic [15:0] ADLER_MOD  = 16'd65521;
  localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

  localparam int unsigned MAX_BPB = 16;

  // Per-beat terms for a 16-byte beat:
  //   k  <= 16, S1 <= 16*255 = 4080, S2 <= 136*255 = 34680.
  localparam int unsigned K_W   = 5;
  localparam int unsigned S1_W  = 12;
  localparam int unsigned S2_W  = 16;
  localparam int unsigned SUM_W = 16;
  // Accumulator operands before reduction stay below 2^26.
  localparam int unsigned RED_W = 26;

  function automatic logic [K_W-1:0] popcount(input logic [MAX_BPB-1:0] v);
    logic [K_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_BPB; i++) begin
      n = n + K_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [SUM_W-1:0] mod_once(input logic [SUM_W-1:0] v);
    return (v >= ADLER_MOD) ? (v - ADLER_MOD) : v;
  endfunction

endpackage

// File: rtl/adler32_mod_reduce.sv
// Combinational reducer: 26-bit operand -> value mod 65521, without a divider.
//
// Ports:
//   value   in  26  operand, any value below 2^26
//   result  out 16  value mod 65521
//
// Because 2^16 == 15 (mod 65521), the high part is folded back as hi*15 + lo.
// Two folds bring any 26-bit input below 65551, and a single conditional
// subtract finishes the reduction.
module adler32_mod_reduce
  import adler32_pkg::*;
(
  input  logic [RED_W-1:0] value,
  output logic [SUM_W-1:0] result
);

  logic [16:0] fold1;
  logic [16:0] fold2;

  always_comb begin
    // <= 65535 + 1023*15 = 80880
    fold1  = 17'(value[15:0]) + 17'(value[RED_W-1:16]) * 17'd15;
    // <= 65535, or <= 15344 + 15 when bit 16 was set
    fold2  = 17'(fold1[15:0]) + (fold1[16] ? 17'd15 : 17'd0);
    result = (fold2 >= 17'(ADLER_MOD)) ? SUM_W'(fold2 - 17'(ADLER_MOD)) : fold2[15:0];
  end

endmodule

// File: rtl/adler32_wide.sv
// Streaming Adler-32 engine taking BYTES_PER_BEAT bytes per clock with a per-byte
// keep mask. Two pipeline stages, no backpressure, back-to-back messages.
//
// Parameters:
//   BYTES_PER_BEAT  bytes per beat (1..16); byte 0 = data[7:0] is earliest in stream
//
// Ports:
//   clock           in   1       rising-edge clock
//   rst             in   1       asynchronous active-high reset
//   data_valid      in   1       beat present (always accepted)
//   data            in   8*BPB   beat payload
//   data_keep       in   BPB     per-byte valid mask
//   last_data       in   1       final beat of message (qualified by data_valid)
//   seed_load       in   1       (ADLER32_SEED_EN only) load seed for next message
//   seed            in   32      (ADLER32_SEED_EN only) {B,A} starting value
//   checksum_valid  out  1       one-cycle pulse when a message completes
//   checksum        out  32      {B,A}; held until the next completion
//
// Configuration macro: ADLER32_SEED_EN adds seed_load/seed so a checksum can be
// resumed across segments. Without it every message starts at A=1, B=0.
//
// Stage 1 condenses a beat into k (kept bytes), S1 (sum of kept bytes) and
// S2 (sum of w_i*d_i, w_i = kept bytes at index >= i). Stage 2 folds them into
// the running sums: A' = A + S1, B' = B + k*A + S2, both mod 65521. This is
// exactly the byte-serial recurrence applied k times.
module adler32_wide
  import adler32_pkg::*;
#(
  parameter int unsigned BYTES_PER_BEAT = 4
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        data_valid,
  input  logic [8*BYTES_PER_BEAT-1:0] data,
  input  logic [BYTES_PER_BEAT-1:0]   data_keep,
  input  logic                        last_data,
`ifdef ADLER32_SEED_EN
  input  logic                        seed_load,
  input  logic [31:0]                 seed,
`endif
  output logic                        checksum_valid,
  output logic [31:0]                 checksum
);

  // ---------------------------------------------------------------------------
  // Stage 1: per-beat reduction
  // ---------------------------------------------------------------------------
  logic [K_W-1:0]  beat_k;
  logic [S1_W-1:0] beat_s1;
  logic [S2_W-1:0] beat_s2;
  logic [K_W-1:0]  lane_w;

  always_comb begin
    lane_w  = '0;
    beat_s1 = '0;
    beat_s2 = '0;
    // Walk from the latest byte back so lane_w counts kept bytes at index >= i.
    for (int i = int'(BYTES_PER_BEAT) - 1; i >= 0; i--) begin
      if (data_keep[i]) begin
        lane_w  = lane_w + K_W'(1);
        beat_s1 = beat_s1 + S1_W'(data[8*i +: 8]);
        beat_s2 = beat_s2 + S2_W'(lane_w) * S2_W'(data[8*i +: 8]);
      end
    end
    beat_k = popcount(MAX_BPB'(data_keep));
  end

  logic            s1_valid_q;
  logic            s1_last_q;
  logic [K_W-1:0]  k_q;
  logic [S1_W-1:0] s1_q;
  logic [S2_W-1:0] s2_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      k_q        <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= data_valid;
      s1_last_q  <= data_valid & last_data;
      if (data_valid) begin
        k_q  <= beat_k;
        s1_q <= beat_s1;
        s2_q <= beat_s2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate and reduce
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] acc_a_q, acc_a_d;
  logic [SUM_W-1:0] acc_b_q, acc_b_d;
  logic [31:0]      checksum_q, checksum_d;
  logic             checksum_valid_q, checksum_valid_d;

  logic [RED_W-1:0] a_sum;
  logic [RED_W-1:0] b_sum;
  logic [SUM_W-1:0] a_next;
  logic [SUM_W-1:0] b_next;
  logic [SUM_W-1:0] start_a;
  logic [SUM_W-1:0] start_b;

  // A + S1 < 2^17; B + 16*A + S2 < 2^21; both well inside the reducer range.
  assign a_sum = RED_W'(acc_a_q) + RED_W'(s1_q);
  assign b_sum = RED_W'(acc_b_q) + RED_W'(k_q) * RED_W'(acc_a_q) + RED_W'(s2_q);

  adler32_mod_reduce u_reduce_a (
    .value  (a_sum),
    .result (a_next)
  );

  adler32_mod_reduce u_reduce_b (
    .value  (b_sum),
    .result (b_next)
  );

`ifdef ADLER32_SEED_EN
  logic             seed_pend_q, seed_pend_d;
  logic [SUM_W-1:0] seed_a_q, seed_a_d;
  logic [SUM_W-1:0] seed_b_q, seed_b_d;
  logic             in_msg_q, in_msg_d;
`endif

  always_comb begin
    acc_a_d          = acc_a_q;
    acc_b_d          = acc_b_q;
    checksum_d       = checksum_q;
    checksum_valid_d = 1'b0;
    start_a          = ADLER_INIT[15:0];
    start_b          = ADLER_INIT[31:16];

`ifdef ADLER32_SEED_EN
    seed_pend_d = seed_pend_q;
    seed_a_d    = seed_a_q;
    seed_b_d    = seed_b_q;
    in_msg_d    = in_msg_q;

    if (seed_pend_q) begin
      start_a = seed_a_q;
      start_b = seed_b_q;
    end
    // Between messages with stage 2 quiet: the seed lands in the accumulator now.
    if (seed_pend_q && !s1_valid_q && !in_msg_q) begin
      acc_a_d     = seed_a_q;
      acc_b_d     = seed_b_q;
      seed_pend_d = 1'b0;
    end
    if (s1_valid_q) begin
      in_msg_d = !s1_last_q;
      // A pending seed is consumed by the reload that follows a last beat.
      if (s1_last_q) begin
        seed_pend_d = 1'b0;
      end
    end
    if (seed_load) begin
      seed_pend_d = 1'b1;
      seed_a_d    = mod_once(seed[15:0]);
      seed_b_d    = mod_once(seed[31:16]);
    end
`endif

    if (s1_valid_q) begin
      if (s1_last_q) begin
        checksum_d       = {b_next, a_next};
        checksum_valid_d = 1'b1;
        acc_a_d          = start_a;
        acc_b_d          = start_b;
      end else begin
        acc_a_d = a_next;
        acc_b_d = b_next;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      acc_a_q          <= ADLER_INIT[15:0];
      acc_b_q          <= ADLER_INIT[31:16];
      checksum_q       <= ADLER_INIT;
      checksum_valid_q <= 1'b0;
    end else begin
      acc_a_q          <= acc_a_d;
      acc_b_q          <= acc_b_d;
      checksum_q       <= checksum_d;
      checksum_valid_q <= checksum_valid_d;
    end
  end

`ifdef ADLER32_SEED_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      seed_pend_q <= 1'b0;
      seed_a_q    <= ADLER_INIT[15:0];
      seed_b_q    <= ADLER_INIT[31:16];
      in_msg_q    <= 1'b0;
    end else begin
      seed_pend_q <= seed_pend_d;
      seed_a_q    <= seed_a_d;
      seed_b_q    <= seed_b_d;
      in_msg_q    <= in_msg_d;
    end
  end
`endif

  assign checksum       = checksum_q;
  assign checksum_valid = checksum_valid_q;

endmodule

// File: tb/tb_adler32_wide.sv
// Scoreboard bench for adler32_wide (default build, 4 bytes per beat).
// Stimulus pushes the expected checksum of each message; the monitor pops on
// every checksum_valid pulse and also checks reset values and the held output.
module tb_adler32_wide;

  localparam int unsigned BPB = 4;

  typedef byte unsigned bq_t[$];

  logic             clock      = 1'b0;
  logic             rst        = 1'b1;
  logic             data_valid = 1'b0;
  logic [8*BPB-1:0] data       = '0;
  logic [BPB-1:0]   data_keep  = '0;
  logic             last_data  = 1'b0;
  logic             checksum_valid;
  logic [31:0]      checksum;

  int          checks   = 0;
  int          errors   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held     = 32'h0000_0001;
  bit          end_req  = 1'b0;
  bit          end_done = 1'b0;

  always #5 clock = ~clock;

  adler32_wide #(
    .BYTES_PER_BEAT (BPB)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .data_valid     (data_valid),
    .data           (data),
    .data_keep      (data_keep),
    .last_data      (last_data),
    .checksum_valid (checksum_valid),
    .checksum       (checksum)
  );

  // Reference: plain byte-serial Adler-32.
  function automatic logic [31:0] adler_ref(input bq_t m);
    int unsigned a = 1;
    int unsigned b = 0;
    foreach (m[i]) begin
      a = (a + m[i]) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s.getc(i));
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    logic [31:0] e;
    if (rst) begin
      checks++;
      if (checksum_valid !== 1'b0 || checksum !== 32'h0000_0001) begin
        errors++;
        $display("FAIL reset_state: valid=%0b checksum=%h, required valid=0 checksum=00000001",
                 checksum_valid, checksum);
      end
      held = 32'h0000_0001;
    end else if (checksum_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: checksum=%h, required no pulse", checksum);
      end else begin
        e    = exp_q.pop_front();
        held = e;
        if (checksum !== e) begin
          errors++;
          $display("FAIL checksum: got %h, required %h", checksum, e);
        end
      end
    end else begin
      checks++;
      if (checksum !== held) begin
        errors++;
        $display("FAIL checksum_hold: got %h, required %h", checksum, held);
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_pulses: %0d outstanding, required 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [8*BPB-1:0] d, input logic [BPB-1:0] k,
                       input logic l);
    @(negedge clock);
    data_valid = v;
    data       = d;
    data_keep  = k;
    last_data  = l;
  endtask

  // Bubbles carry garbage on data/keep/last, which must be ignored.
  task automatic idle(input int n);
    repeat (n) drive(1'b0, (8*BPB)'($urandom), BPB'($urandom), 1'($urandom));
  endtask

  // mode 0: dense lanes, 1: random keep holes, 2: one byte per beat in a random lane
  task automatic send_msg(input bq_t m, input int mode, input int max_gap);
    int               idx;
    int               lane;
    logic [8*BPB-1:0] d;
    logic [BPB-1:0]   k;
    idx = 0;
    if (m.size() == 0) begin
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      drive(1'b1, (8*BPB)'($urandom), '0, 1'b1);
      return;
    end
    while (idx < m.size()) begin
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      d = (8*BPB)'($urandom);
      k = '0;
      if (mode == 2) begin
        lane           = int'($urandom_range(BPB - 1, 0));
        d[8*lane +: 8] = m[idx];
        k[lane]        = 1'b1;
        idx++;
      end else begin
        for (int i = 0; i < int'(BPB); i++) begin
          if (idx < m.size() && (mode == 0 || $urandom_range(3, 0) != 0)) begin
            d[8*i +: 8] = m[idx];
            k[i]        = 1'b1;
            idx++;
          end
        end
      end
      drive(1'b1, d, k, idx == m.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bq_t m;
    bq_t empty;

    repeat (3) @(negedge clock);
    #2 rst = 1'b0;

    // "Hello", one byte per beat with random gaps
    exp_q.push_back(32'h058C01F5);
    send_msg(str2q("Hello"), 2, 3);
    idle(4);

    // "Hell" full beat, then "o" + last
    exp_q.push_back(32'h058C01F5);
    drive(1'b1, 32'h6C6C6548, 4'hF, 1'b0);
    drive(1'b1, 32'hA5C3E16F, 4'h1, 1'b1);
    idle(4);

    // "Wikipedia" in three beats
    exp_q.push_back(32'h11E60398);
    drive(1'b1, 32'h696B6957, 4'hF, 1'b0);
    drive(1'b1, 32'h69646570, 4'hF, 1'b0);
    drive(1'b1, 32'h5A5A5A61, 4'h1, 1'b1);
    idle(4);

    // "Wikipedia" again with keep holes
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(32'h11E60398);
      send_msg(str2q("Wikipedia"), 1, 2);
    end
    idle(4);

    // 1024 x 0xFF: wraps both sums
    m.delete();
    repeat (1024) m.push_back(8'hFF);
    exp_q.push_back(32'h79A6FC2E);
    send_msg(m, 0, 0);
    idle(4);

    // Empty message back-to-back with "Hello"
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h058C01F5);
    send_msg(empty, 0, 0);
    send_msg(str2q("Hello"), 0, 0);
    idle(4);

    // Reset mid-message: partial "Hell" + "o" without last, then abort
    drive(1'b1, 32'h6C6C6548, 4'hF, 1'b0);
    drive(1'b1, 32'h0000006F, 4'h1, 1'b0);
    idle(1);
    @(negedge clock);
    #2 rst = 1'b1;
    data_valid = 1'b0;
    repeat (2) @(negedge clock);
    #2 rst = 1'b0;
    exp_q.push_back(32'h058C01F5);
    send_msg(str2q("Hello"), 1, 2);
    idle(4);

    // Randomised messages checked against the reference model
    for (int n = 0; n < 40; n++) begin
      int len;
      len = (n % 8 == 0) ? int'($urandom_range(600, 200)) : int'($urandom_range(40, 0));
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      exp_q.push_back(adler_ref(m));
      send_msg(m, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
    end

    // Drain with a bounded wait
    idle(1);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock);
    end_req = 1'b1;
    while (!end_done) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
